fir_sum_reader: RTL and testbench

Read-side drain for the FIR filter core's output queue, running in the clk3 domain.
- Pops filtered sums from the core whenever the queue is non-empty and local space exists.
- Rounds, shifts and saturates each 32-bit sum to an output sample width.
- Buffers results in a small FIFO and presents them on a valid/ready stream to downstream logic (DAC/serialiser).

---
 rtl/fir_pkg.sv | 50 +++++
 rtl/fir_out_fifo.sv | 52 +++++
 rtl/fir_sum_reader.sv | 119 +++++++++++
 tb/tb_fir_sum_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, state encodings and sample arithmetic for the FIR filter blocks.
package fir_pkg;

  localparam int unsigned FIR_SUM_W = 32;
  localparam int unsigned FIR_OUT_W = 16;

  // Reader FSM state encodings.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  // Output sample saturation limits.
  localparam logic [FIR_OUT_W-1:0] OUT_MAX = {1'b0, {(FIR_OUT_W-1){1'b1}}};
  localparam logic [FIR_OUT_W-1:0] OUT_MIN = {1'b1, {(FIR_OUT_W-1){1'b0}}};

  // The same limits sign-extended to the widened sum width used for comparison.
  localparam logic signed [FIR_SUM_W:0] LIM_MAX =
    {{(FIR_SUM_W-FIR_OUT_W+2){1'b0}}, {(FIR_OUT_W-1){1'b1}}};
  localparam logic signed [FIR_SUM_W:0] LIM_MIN =
    {{(FIR_SUM_W-FIR_OUT_W+2){1'b1}}, {(FIR_OUT_W-1){1'b0}}};

  typedef struct packed {
    logic                 sat;
    logic [FIR_OUT_W-1:0] data;
  } sample_t;

  // Round-half-up, arithmetic shift, then clamp to the output sample range.
  function automatic sample_t round_shift_sat(input logic [FIR_SUM_W-1:0] sum,
                                              input int unsigned          shift);
    logic signed [FIR_SUM_W:0] rnd;
    logic signed [FIR_SUM_W:0] r;
    logic signed [FIR_SUM_W:0] s;
    sample_t                   res;
    rnd = (shift > 0) ? ((FIR_SUM_W+1)'(1) << (shift - 1)) : '0;
    r   = $signed({sum[FIR_SUM_W-1], sum}) + rnd;
    s   = r >>> shift;
    if (s > LIM_MAX) begin
      res.sat  = 1'b1;
      res.data = OUT_MAX;
    end else if (s < LIM_MIN) begin
      res.sat  = 1'b1;
      res.data = OUT_MIN;
    end else begin
      res.sat  = 1'b0;
      res.data = s[FIR_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Small power-of-two FIFO holding processed output samples; head is always visible.
module fir_out_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     occ,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      occ_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (occ_q == '0);
  assign full     = (occ_q == (AW+1)'(DEPTH));
  assign occ      = occ_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_pop   = pop && !empty;
  // A push at full is only legal when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      occ_q <= occ_q + (AW+1)'(1);
      else if (!do_push && do_pop) occ_q <= occ_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_sum_reader.sv
// Drains filtered sums from the FIR core queue, scales them to output samples and
// streams them downstream through a small FIFO.
module fir_sum_reader
  import fir_pkg::*;
#(
  parameter int unsigned SUM_W     = FIR_SUM_W,
  parameter int unsigned OUT_W     = FIR_OUT_W,
  parameter int unsigned SHIFT     = 4,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic             clk3,
  input  logic             reset,
  input  logic             enable,
  input  logic             empty,
  output logic             read,
  input  logic [SUM_W-1:0] sum,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat_seen,
  output logic [15:0]      sample_count
);

  localparam int unsigned OccW = $clog2(OUT_DEPTH) + 1;

  localparam logic signed [SUM_W:0] Rnd    = (SUM_W+1)'((2 ** SHIFT) / 2);
  localparam logic signed [SUM_W:0] LimMax = {{(SUM_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] LimMin = {{(SUM_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]          state_q, state_d;
  logic                read_q;
  logic                in_flight_q;
  logic [READ_LAT-1:0] cap_q;
  logic                sat_q;
  logic [15:0]         count_q;

  logic                capture;
  logic                issue;
  logic [OccW-1:0]     occ;
  logic                fifo_full;
  logic                fifo_empty;
  logic signed [SUM_W:0] r;
  logic signed [SUM_W:0] s;
  logic                sat_hi;
  logic                sat_lo;
  logic [OUT_W-1:0]    sample;

  assign capture      = cap_q[READ_LAT-1];
  assign read         = read_q;
  assign busy         = (state_q != StIdle);
  assign sat_seen     = sat_q;
  assign sample_count = count_q;
  assign out_valid    = !fifo_empty;

  // Credit counts the outstanding read so a capture always has room in the FIFO.
  assign issue = (state_q == StRun) && !empty && !in_flight_q && !fifo_full &&
                 (((OccW+1)'(occ) + (OccW+1)'(in_flight_q)) < (OccW+1)'(OUT_DEPTH));

  // Round, shift and saturate the captured sum.
  always_comb begin
    r      = $signed({sum[SUM_W-1], sum}) + Rnd;
    s      = r >>> SHIFT;
    sat_hi = (s > LimMax);
    sat_lo = (s < LimMin);
    sample = s[OUT_W-1:0];
    if (sat_hi)      sample = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) sample = {1'b1, {(OUT_W-1){1'b0}}};
  end

  // Next-state logic for the IDLE/RUN/FLUSH controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StFlush;
      StFlush: if (!in_flight_q) state_d = enable ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Controller state, read pulse, capture timing and status registers.
  always_ff @(posedge clk3) begin
    if (reset) begin
      state_q     <= StIdle;
      read_q      <= 1'b0;
      in_flight_q <= 1'b0;
      cap_q       <= '0;
      sat_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= issue;
      cap_q[0] <= read_q;
      for (int i = 1; i < int'(READ_LAT); i++) cap_q[i] <= cap_q[i-1];
      if (issue)        in_flight_q <= 1'b1;
      else if (capture) in_flight_q <= 1'b0;
      if (capture && (sat_hi || sat_lo)) sat_q <= 1'b1;
      if (capture) count_q <= count_q + 16'd1;
    end
  end

  fir_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk3),
    .reset     (reset),
    .push      (capture),
    .push_data (sample),
    .pop       (out_valid && out_ready),
    .pop_data  (out_data),
    .occ       (occ),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fir_sum_reader.sv
// Scoreboard bench for fir_sum_reader: a READ_LAT=1 instance with a modelled core
// queue, plus a READ_LAT=3 instance for the flush scenario.
module tb_fir_sum_reader;

  logic        clk3 = 1'b0;
  logic        reset;

  logic        enable1, empty1, read1, out_valid1, out_ready1, busy1, sat1;
  logic [31:0] sum1;
  logic [15:0] out_data1, cnt1;

  logic        enable3, empty3, read3, out_valid3, out_ready3, busy3, sat3;
  logic [31:0] sum3;
  logic [15:0] out_data3, cnt3;

  int errors = 0;
  int checks = 0;

  logic [31:0] core_q[$];
  logic [15:0] exp_q[$];
  int cyc = 0;
  int last_rd = -100;
  int rd1 = 0;
  int rd3 = 0;
  int out3 = 0;

  always #5 clk3 = ~clk3;

  fir_sum_reader #(
    .SUM_W(32), .OUT_W(16), .SHIFT(4), .READ_LAT(1), .OUT_DEPTH(4)
  ) u_dut1 (
    .clk3         (clk3),
    .reset        (reset),
    .enable       (enable1),
    .empty        (empty1),
    .read         (read1),
    .sum          (sum1),
    .out_data     (out_data1),
    .out_valid    (out_valid1),
    .out_ready    (out_ready1),
    .busy         (busy1),
    .sat_seen     (sat1),
    .sample_count (cnt1)
  );

  fir_sum_reader #(
    .SUM_W(32), .OUT_W(16), .SHIFT(4), .READ_LAT(3), .OUT_DEPTH(4)
  ) u_dut3 (
    .clk3         (clk3),
    .reset        (reset),
    .enable       (enable3),
    .empty        (empty3),
    .read         (read3),
    .sum          (sum3),
    .out_data     (out_data3),
    .out_valid    (out_valid3),
    .out_ready    (out_ready3),
    .busy         (busy3),
    .sat_seen     (sat3),
    .sample_count (cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Core model for instance 1: one-cycle read latency, empty follows queue contents.
  initial begin
    empty1 = 1'b1;
    sum1   = '0;
  end
  always @(posedge clk3) begin
    cyc <= cyc + 1;
    if (read1) begin
      check("read_gap_ge2", 32'(int'((cyc - last_rd) >= 2)), 32'd1);
      check("read_not_empty", 32'(int'(core_q.size() > 0)), 32'd1);
      last_rd <= cyc;
      rd1     <= rd1 + 1;
      if (core_q.size() > 0) sum1 <= core_q.pop_front();
    end
    empty1 <= (core_q.size() == 0);
  end

  // Monitor for instance 1: every accepted sample is matched against the scoreboard.
  always @(negedge clk3) begin
    if (!reset && out_valid1 && out_ready1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out1: got %0d, expected no output", out_data1);
      end else begin
        check("out_data1", 32'(out_data1), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk3) if (read3) rd3 <= rd3 + 1;

  always @(negedge clk3) begin
    if (!reset && out_valid3 && out_ready3) begin
      check("out_data3", 32'(out_data3), 32'd63);
      out3 <= out3 + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk3);
      #2;
    end
  endtask

  task automatic issue(input logic [31:0] s, input logic [15:0] e);
    core_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int maxc);
    int k = 0;
    while ((exp_q.size() != 0 || core_q.size() != 0) && k < maxc) begin
      tick(1);
      k++;
    end
    check({name, "_drain_in_time"}, 32'(int'(k < maxc)), 32'd1);
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    int k;
    logic [31:0] seq_in [6];
    logic [15:0] seq_out[6];
    seq_in  = '{32'd1000, 32'd2000, 32'd3000, 32'd4000, 32'd5000, 32'd6000};
    seq_out = '{16'd63, 16'd125, 16'd188, 16'd250, 16'd313, 16'd375};

    reset = 1'b1;
    enable1 = 1'b0; out_ready1 = 1'b1;
    enable3 = 1'b0; empty3 = 1'b1; sum3 = 32'd1000; out_ready3 = 1'b1;
    tick(3);
    check("rst_read",      32'(read1),      32'd0);
    check("rst_out_valid", 32'(out_valid1), 32'd0);
    check("rst_out_data",  32'(out_data1),  32'd0);
    check("rst_busy",      32'(busy1),      32'd0);
    check("rst_sat_seen",  32'(sat1),       32'd0);
    check("rst_count",     32'(cnt1),       32'd0);
    reset = 1'b0;
    tick(1);
    enable1 = 1'b1;
    tick(2);
    check("run_busy", 32'(busy1), 32'd1);
    check("idle_no_read", 32'(rd1), 32'd0);

    // Single sum.
    issue(32'd1000, 16'd63);
    drain("single", 50);
    check("single_reads", 32'(rd1), 32'd1);
    check("single_count", 32'(cnt1), 32'd1);
    check("single_sat", 32'(sat1), 32'd0);

    // Ordered sequence.
    for (int i = 0; i < 6; i++) issue(seq_in[i], seq_out[i]);
    drain("seq", 100);
    check("seq_reads", 32'(rd1), 32'd7);
    check("seq_count", 32'(cnt1), 32'd7);

    // Backpressure: only FIFO-depth reads may be outstanding.
    out_ready1 = 1'b0;
    base = rd1;
    issue(32'd7000, 16'd438);
    issue(32'd8000, 16'd500);
    issue(32'd9000, 16'd563);
    issue(32'd10000, 16'd625);
    issue(32'd11000, 16'd688);
    issue(32'd12000, 16'd750);
    tick(30);
    check("bp_reads_held", 32'(rd1 - base), 32'd4);
    check("bp_valid", 32'(out_valid1), 32'd1);
    check("bp_head_stable", 32'(out_data1), 32'd438);
    check("bp_core_left", 32'(core_q.size()), 32'd2);
    out_ready1 = 1'b1;
    drain("bp", 100);
    check("bp_reads_all", 32'(rd1 - base), 32'd6);
    check("bp_count", 32'(cnt1), 32'd13);

    // Saturation and sign handling.
    issue(32'h0010_0000, 16'h7FFF);
    drain("sat_pos", 50);
    check("sat_seen_set", 32'(sat1), 32'd1);
    issue(32'hFFFF_FC18, 16'hFFC2);
    issue(32'h8000_0000, 16'h8000);
    drain("sat_neg", 50);
    check("sat_seen_sticky", 32'(sat1), 32'd1);
    check("sat_count", 32'(cnt1), 32'd16);

    // Reset while a read is outstanding and two samples are buffered.
    out_ready1 = 1'b0;
    base = rd1;
    issue(32'd1000, 16'd63);
    issue(32'd2000, 16'd125);
    issue(32'd3000, 16'd188);
    k = 0;
    while (!(read1 && (rd1 - base) == 2) && k < 100) begin
      tick(1);
      k++;
    end
    check("midrst_reach_third_read", 32'(int'(k < 100)), 32'd1);
    check("midrst_pre_valid", 32'(out_valid1), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    check("midrst_valid", 32'(out_valid1), 32'd0);
    check("midrst_count", 32'(cnt1), 32'd0);
    check("midrst_sat", 32'(sat1), 32'd0);
    tick(5);
    check("midrst_no_stale_push", 32'(out_valid1), 32'd0);
    check("midrst_count_hold", 32'(cnt1), 32'd0);
    out_ready1 = 1'b1;
    issue(32'd1000, 16'd63);
    drain("post_rst", 50);
    check("post_rst_count", 32'(cnt1), 32'd1);

    // Flush on the READ_LAT=3 instance: enable drops the cycle after the read.
    enable3 = 1'b1;
    empty3  = 1'b0;
    k = 0;
    while (!read3 && k < 50) begin
      tick(1);
      k++;
    end
    check("flush_read_seen", 32'(int'(k < 50)), 32'd1);
    tick(1);
    enable3 = 1'b0;
    tick(2);
    check("flush_busy_at_capture", 32'(busy3), 32'd1);
    tick(20);
    check("flush_idle", 32'(busy3), 32'd0);
    check("flush_reads", 32'(rd3), 32'd1);
    check("flush_delivered", 32'(out3), 32'd1);
    check("flush_count", 32'(cnt3), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
